// File: rtl/cam_capture_win_pkg.sv
// Shared types and helpers for the camera capture window path.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cam_state_e;

    localparam int SYNC_STAGES = 2;

    function automatic int unsigned ceil_half(input int unsigned v);
        return (v >> 1) + (v & 32'd1);
    endfunction

endpackage

// File: rtl/cam_capture_win_if.sv
// Frame-buffer write port: one strobe, linear address and pixel word.
interface cam_capture_win_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_capture_win_in_sync.sv
// Brings the camera pins into the clk domain and flags pclk/href/vsync edges.
module cam_in_sync
    import cam_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pclk,
    input  logic          href,
    input  logic          vsync,
    input  logic [DW-1:0] d,
    output logic          pclk_rise,
    output logic          href_lvl,
    output logic          href_rise,
    output logic          href_fall,
    output logic          vsync_rise,
    output logic          vsync_fall,
    output logic [DW-1:0] d_s
);
    // ctl bit order: {vsync, href, pclk}; data travels through the same depth
    logic [2:0]    ctl_q [SYNC_STAGES];
    logic [DW-1:0] dat_q [SYNC_STAGES];
    logic [2:0]    ctl_prev_q;
    logic [2:0]    ctl_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ctl_q[i] <= '0;
                dat_q[i] <= '0;
            end
            ctl_prev_q <= '0;
        end else begin
            ctl_q[0] <= {vsync, href, pclk};
            dat_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ctl_q[i] <= ctl_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            ctl_prev_q <= ctl_q[SYNC_STAGES-1];
        end
    end

    assign ctl_s      = ctl_q[SYNC_STAGES-1];
    assign d_s        = dat_q[SYNC_STAGES-1];
    assign pclk_rise  = ctl_s[0] & ~ctl_prev_q[0];
    assign href_lvl   = ctl_s[1];
    assign href_rise  = ctl_s[1] & ~ctl_prev_q[1];
    assign href_fall  = ~ctl_s[1] & ctl_prev_q[1];
    assign vsync_rise = ctl_s[2] & ~ctl_prev_q[2];
    assign vsync_fall = ~ctl_s[2] & ctl_prev_q[2];

endmodule

// File: rtl/cam_capture_win.sv
// Camera capture path: pixel assembly, crop window with 2:1 decimation,
// linear frame-buffer writes and per-frame status.
module cam_capture_win
    import cam_pkg::*;
#(
    parameter int DW        = 8,
    parameter int PIX_BYTES = 2,
    parameter int ADDR_W    = 17,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cam_pclk,
    input  logic             cam_href,
    input  logic             cam_vsync,
    input  logic [DW-1:0]    cam_d,
    input  logic             cfg_en,
    input  logic             cfg_single,
    input  logic             cfg_decim,
    input  logic [CNT_W-1:0] cfg_x0,
    input  logic [CNT_W-1:0] cfg_y0,
    input  logic [CNT_W-1:0] cfg_w,
    input  logic [CNT_W-1:0] cfg_h,
    cam_capture_win_if.master fb,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frame_cnt,
    output logic             err_short,
    output logic             err_ovf
);
    localparam int                PIX_W    = DW * PIX_BYTES;
    localparam logic [1:0]        PH_LAST  = 2'(PIX_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic pclk_rise, href_lvl, href_rise, href_fall, vsync_rise, vsync_fall;
    logic [DW-1:0] d_s;

    cam_in_sync #(.DW(DW)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pclk       (cam_pclk),
        .href       (cam_href),
        .vsync      (cam_vsync),
        .d          (cam_d),
        .pclk_rise  (pclk_rise),
        .href_lvl   (href_lvl),
        .href_rise  (href_rise),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .d_s        (d_s)
    );

    cam_state_e        state_q, state_d;
    logic [1:0]        phase_q, phase_d, ph;
    logic [PIX_W-1:0]  sh_q, sh_d, pix_word;
    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic [CNT_W:0]    lines_q, lines_d, lines_now, lines_exp;
    logic              line_pix_q, line_pix_d, line_hit_q, line_hit_d;
    logic              full_q, full_d, en_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic              decim_q, decim_d, single_q, single_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              err_short_q, err_short_d, err_ovf_q, err_ovf_d;
    logic              pix_en, pix_done, hit, in_win, decim_ok;
    logic              line_pix_now, line_hit_now;

    // Window bounds compared one bit wider so x0+w never wraps
    assign decim_ok = !decim_q || ((x_q[0] == x0_q[0]) && (y_q[0] == y0_q[0]));
    assign in_win   = ({1'b0, x_q} >= {1'b0, x0_q}) && ({1'b0, x_q} < ({1'b0, x0_q} + {1'b0, w_q})) &&
                      ({1'b0, y_q} >= {1'b0, y0_q}) && ({1'b0, y_q} < ({1'b0, y0_q} + {1'b0, h_q})) &&
                      decim_ok;
    assign lines_exp = decim_q ? (CNT_W+1)'(ceil_half(32'(h_q))) : {1'b0, h_q};

    always_comb begin
        state_d = state_q;     phase_d = phase_q;     sh_d = sh_q;
        x_d = x_q;             y_d = y_q;             lines_d = lines_q;
        line_pix_d = line_pix_q;  line_hit_d = line_hit_q;
        full_d = full_q;       addr_d = addr_q;
        x0_d = x0_q;  y0_d = y0_q;  w_d = w_q;  h_d = h_q;
        decim_d = decim_q;     single_d = single_q;
        wr_en_d = 1'b0;        wr_addr_d = wr_addr_q; wr_data_d = wr_data_q;
        done_d = 1'b0;         fcnt_d = fcnt_q;
        err_short_d = err_short_q;  err_ovf_d = err_ovf_q;

        // A byte arriving on the href-fall cycle still belongs to the line
        ph       = href_rise ? 2'd0 : phase_q;
        pix_en   = pclk_rise & (href_lvl | href_fall);
        pix_word = PIX_W'({sh_q, d_s});
        pix_done = pix_en && (ph == PH_LAST);
        phase_d  = ph;
        if (pix_en) begin
            sh_d    = pix_word;
            phase_d = pix_done ? 2'd0 : ph + 2'd1;
        end
        if (href_fall) phase_d = 2'd0;

        hit = pix_done && in_win && (state_q == CAPTURE);
        if (pix_done) x_d = x_q + 1'b1;
        if (hit) begin
            if (full_q) begin
                err_ovf_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = pix_word;
                if (addr_q == ADDR_MAX) full_d = 1'b1;
                else                    addr_d = addr_q + 1'b1;
            end
        end

        line_pix_now = line_pix_q | pix_done;
        line_hit_now = line_hit_q | hit;
        lines_now    = lines_q + (CNT_W+1)'(line_hit_now);
        line_pix_d   = line_pix_now;
        line_hit_d   = line_hit_now;
        if (href_fall) begin
            x_d        = '0;
            if (line_pix_now) y_d = y_q + 1'b1;
            lines_d    = lines_now;
            line_pix_d = 1'b0;
            line_hit_d = 1'b0;
        end

        case (state_q)
            IDLE:    if (cfg_en) state_d = WAIT_VS;
            WAIT_VS: if (vsync_fall) begin
                state_d  = CAPTURE;
                x0_d = cfg_x0;  y0_d = cfg_y0;  w_d = cfg_w;  h_d = cfg_h;
                decim_d  = cfg_decim;
                single_d = cfg_single;
                x_d = '0;  y_d = '0;  lines_d = '0;
                line_pix_d = 1'b0;  line_hit_d = 1'b0;
                full_d = 1'b0;  addr_d = '0;  wr_addr_d = '0;
            end
            CAPTURE: if (vsync_rise) begin
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
                if (lines_now < lines_exp) err_short_d = 1'b1;
                state_d = single_q ? DONE : WAIT_VS;
            end
            DONE:    ;
            default: state_d = IDLE;
        endcase

        if (!cfg_en) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            fcnt_d      = fcnt_q;
            err_short_d = err_short_q;
        end
        if (cfg_en && !en_prev_q) begin
            err_short_d = 1'b0;
            err_ovf_d   = 1'b0;
        end
        busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;   phase_q <= '0;   sh_q <= '0;
            x_q <= '0;   y_q <= '0;   lines_q <= '0;
            line_pix_q <= 1'b0;   line_hit_q <= 1'b0;
            full_q <= 1'b0;   addr_q <= '0;   en_prev_q <= 1'b0;
            x0_q <= '0;   y0_q <= '0;   w_q <= '0;   h_q <= '0;
            decim_q <= 1'b0;   single_q <= 1'b0;
            wr_en_q <= 1'b0;   wr_addr_q <= '0;   wr_data_q <= '0;
            busy_q <= 1'b0;   done_q <= 1'b0;   fcnt_q <= '0;
            err_short_q <= 1'b0;   err_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;   phase_q <= phase_d;   sh_q <= sh_d;
            x_q <= x_d;   y_q <= y_d;   lines_q <= lines_d;
            line_pix_q <= line_pix_d;   line_hit_q <= line_hit_d;
            full_q <= full_d;   addr_q <= addr_d;   en_prev_q <= cfg_en;
            x0_q <= x0_d;   y0_q <= y0_d;   w_q <= w_d;   h_q <= h_d;
            decim_q <= decim_d;   single_q <= single_d;
            wr_en_q <= wr_en_d;   wr_addr_q <= wr_addr_d;   wr_data_q <= wr_data_d;
            busy_q <= busy_d;   done_q <= done_d;   fcnt_q <= fcnt_d;
            err_short_q <= err_short_d;   err_ovf_q <= err_ovf_d;
        end
    end

    assign fb.wr_en    = wr_en_q;
    assign fb.wr_addr  = wr_addr_q;
    assign fb.wr_data  = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_cnt   = fcnt_q;
    assign err_short   = err_short_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cam_capture_win.sv
// Scoreboard bench: a full-size and a 3-bit-address instance share one camera stream.
module tb_cam_capture_win;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_pclk, cam_href, cam_vsync;
    logic [7:0]  cam_d;
    logic        cfg_en, cfg_single, cfg_decim;
    logic [11:0] cfg_x0, cfg_y0, cfg_w, cfg_h;
    logic        busy1, done1, es1, eo1, busy2, done2, es2, eo2;
    logic [7:0]  fcnt1, fcnt2;

    always #5 clk = ~clk;

    cam_capture_win_if #(.ADDR_W(17), .PIX_W(16)) fb1 ();
    cam_capture_win_if #(.ADDR_W(3),  .PIX_W(16)) fb2 ();

    cam_capture_win #(.DW(8), .PIX_BYTES(2), .ADDR_W(17), .CNT_W(12)) dut1 (
        .clk(clk), .rst_n(rst_n), .cam_pclk(cam_pclk), .cam_href(cam_href),
        .cam_vsync(cam_vsync), .cam_d(cam_d), .cfg_en(cfg_en), .cfg_single(cfg_single),
        .cfg_decim(cfg_decim), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .fb(fb1.master), .busy(busy1), .frame_done(done1), .frame_cnt(fcnt1),
        .err_short(es1), .err_ovf(eo1)
    );

    cam_capture_win #(.DW(8), .PIX_BYTES(2), .ADDR_W(3), .CNT_W(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .cam_pclk(cam_pclk), .cam_href(cam_href),
        .cam_vsync(cam_vsync), .cam_d(cam_d), .cfg_en(cfg_en), .cfg_single(cfg_single),
        .cfg_decim(cfg_decim), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .fb(fb2.master), .busy(busy2), .frame_done(done2), .frame_cnt(fcnt2),
        .err_short(es2), .err_ovf(eo2)
    );

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  done_cnt1 = 0, done_cnt2 = 0;
    int  exp_done = 0, exp_fc = 0;
    int  cx0, cy0, cw, ch;
    bit  cdec;
    bit  exp_short = 0, exp_ovf1 = 0, exp_ovf2 = 0, done_state = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && fb1.wr_en === 1'b1) begin
            $display("dut1 write addr=%0d data=%04h", fb1.wr_addr, fb1.wr_data);
            if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                chk("wr1_addr", 64'(fb1.wr_addr), 64'(e.addr));
                chk("wr1_data", 64'(fb1.wr_data), 64'(e.data));
            end
        end
        if (rst_n === 1'b1 && fb2.wr_en === 1'b1) begin
            $display("dut2 write addr=%0d data=%04h", fb2.wr_addr, fb2.wr_data);
            if (q2.size() == 0) chk("wr2_unexpected", 1, 0);
            else begin
                e = q2.pop_front();
                chk("wr2_addr", 64'(fb2.wr_addr), 64'(e.addr));
                chk("wr2_data", 64'(fb2.wr_data), 64'(e.data));
            end
        end
        if (done1 === 1'b1) done_cnt1++;
        if (done2 === 1'b1) done_cnt2++;
    end

    task automatic set_win(input int x0, input int y0, input int w, input int h, input bit dec);
        cx0 = x0; cy0 = y0; cw = w; ch = h; cdec = dec;
        cfg_x0 = 12'(x0); cfg_y0 = 12'(y0); cfg_w = 12'(w); cfg_h = 12'(h); cfg_decim = dec;
    endtask

    task automatic set_en(input bit v);
        if (v && !cfg_en) begin
            exp_short = 0; exp_ovf1 = 0; exp_ovf2 = 0;
        end
        if (!v) done_state = 0;
        cfg_en = v;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_byte(input int v);
        cam_d = 8'(v);
        repeat (3) @(posedge clk);
        cam_pclk = 1'b1;
        repeat (3) @(posedge clk);
        cam_pclk = 1'b0;
    endtask

    function automatic bit in_win(input int x, input int y);
        bit ok;
        ok = (x >= cx0) && (x < cx0 + cw) && (y >= cy0) && (y < cy0 + ch);
        if (cdec) ok = ok && (((x - cx0) % 2) == 0) && (((y - cy0) % 2) == 0);
        return ok;
    endfunction

    // Sends one fw x fh frame; cap says the DUT is expected to capture it,
    // abort_at drops cfg_en just before that pixel index (-1 = never).
    task automatic cam_frame(input string name, input int fw, input int fh,
                             input bit cap, input int abort_at);
        int b = 1, pix = 0, a1 = 0, a2 = 0, lines_hit = 0, lines_exp;
        bit alive = cap, line_hit;
        wr_t e;
        cam_vsync = 1'b1;
        repeat (8) @(posedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(posedge clk);
        for (int y = 0; y < fh; y++) begin
            line_hit = 0;
            cam_href = 1'b1;
            repeat (4) @(posedge clk);
            for (int x = 0; x < fw; x++) begin
                if (pix == abort_at) begin
                    set_en(0);
                    alive = 0;
                end
                if (alive && in_win(x, y)) begin
                    line_hit = 1;
                    e.data = 32'(((b & 255) << 8) | ((b + 1) & 255));
                    if (a1 < (1 << 17)) begin e.addr = 32'(a1); q1.push_back(e); a1++; end
                    else exp_ovf1 = 1;
                    if (a2 < 8) begin e.addr = 32'(a2); q2.push_back(e); a2++; end
                    else exp_ovf2 = 1;
                end
                send_byte(b);
                send_byte(b + 1);
                b += 2;
                pix++;
            end
            repeat (4) @(posedge clk);
            cam_href = 1'b0;
            repeat (6) @(posedge clk);
            if (line_hit) lines_hit++;
        end
        cam_vsync = 1'b1;
        repeat (12) @(posedge clk);
        if (alive) begin
            exp_done++;
            exp_fc++;
            lines_exp = cdec ? (ch + 1) / 2 : ch;
            if (lines_hit < lines_exp) exp_short = 1;
            if (cfg_single) done_state = 1;
        end
        @(negedge clk);
        $display("frame %s: writes1=%0d writes2=%0d frame_cnt=%0d", name, a1, a2, fcnt1);
        chk({name, "_q1_left"}, 64'(q1.size()), 0);
        chk({name, "_q2_left"}, 64'(q2.size()), 0);
        chk({name, "_done1"}, 64'(done_cnt1), 64'(exp_done));
        chk({name, "_done2"}, 64'(done_cnt2), 64'(exp_done));
        chk({name, "_fcnt1"}, 64'(fcnt1), 64'(exp_fc % 256));
        chk({name, "_fcnt2"}, 64'(fcnt2), 64'(exp_fc % 256));
        chk({name, "_short1"}, 64'(es1), 64'(exp_short));
        chk({name, "_short2"}, 64'(es2), 64'(exp_short));
        chk({name, "_ovf1"}, 64'(eo1), 64'(exp_ovf1));
        chk({name, "_ovf2"}, 64'(eo2), 64'(exp_ovf2));
        chk({name, "_busy1"}, 64'(busy1), 64'(cfg_en && !done_state));
        q1.delete();
        q2.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0; cam_d = '0;
        cfg_en = 1'b0; cfg_single = 1'b0;
        set_win(0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en",   64'(fb1.wr_en), 0);
        chk("rst_wr_addr", 64'(fb1.wr_addr), 0);
        chk("rst_wr_data", 64'(fb1.wr_data), 0);
        chk("rst_busy",    64'(busy1), 0);
        chk("rst_done",    64'(done1), 0);
        chk("rst_fcnt",    64'(fcnt1), 0);
        chk("rst_short",   64'(es1), 0);
        chk("rst_ovf",     64'(eo1), 0);
        @(posedge clk);
        rst_n = 1'b1;

        cam_frame("idle", 4, 2, 0, -1);

        set_win(0, 0, 4, 3, 0);
        set_en(1);
        cam_frame("full", 4, 3, 1, -1);

        set_win(2, 1, 3, 2, 0);
        cam_frame("crop", 8, 6, 1, -1);

        set_win(0, 0, 8, 6, 1);
        cam_frame("decim", 8, 6, 1, -1);

        set_en(0);
        set_win(0, 0, 4, 6, 0);
        set_en(1);
        cam_frame("short", 4, 4, 1, -1);

        set_en(0);
        set_win(0, 0, 4, 4, 0);
        set_en(1);
        cam_frame("ovf", 4, 4, 1, -1);

        set_en(0);
        cfg_single = 1'b1;
        set_win(0, 0, 2, 2, 0);
        set_en(1);
        cam_frame("single", 2, 2, 1, -1);
        cam_frame("single_hold", 2, 2, 0, -1);
        set_en(0);
        set_en(1);
        cam_frame("rearm", 2, 2, 1, -1);

        set_en(0);
        cfg_single = 1'b0;
        set_win(0, 0, 4, 2, 0);
        set_en(1);
        cam_frame("abort", 4, 2, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_capture_win.md
Name: cam_capture_win

Overview:
- Parametrised successor to the single-mode OV2640 capture path.
- Sits between the camera pins and the frame-buffer write port.
- Samples pclk/href/vsync/d in the system clock domain, assembles multi-byte pixels and applies a runtime crop window with optional 2:1 decimation.
- Emits linear write address/data/enable plus frame status (done pulse, counter, error flags); supports continuous and single-shot capture.

Parameters:
- DW, 8: camera data bus width.
- PIX_BYTES, 2: bytes per pixel, legal 1..4; PIX_W = DW*PIX_BYTES (derived localparam).
- ADDR_W, 17: frame-buffer address width.
- CNT_W, 12: width of x/y counters and window config fields.

Ports:
- clk  in  1  system clock; must be >= 4x pclk frequency.
- rst_n  in  1  synchronous active-low reset.
- cam_pclk  in  1  camera pixel clock, asynchronous, sampled.
- cam_href  in  1  line valid, active high.
- cam_vsync  in  1  frame sync, high during vertical blanking.
- cam_d  in  DW  camera data.
- cfg_en  in  1  capture enable (level).
- cfg_single  in  1  1 = stop after one frame.
- cfg_decim  in  1  1 = keep every 2nd pixel and every 2nd line of the window.
- cfg_x0, cfg_y0  in  CNT_W  window origin.
- cfg_w, cfg_h  in  CNT_W  window size in source pixels/lines; 0 = no writes.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  PIX_W  pixel data; first byte received goes to the MSBs.
- busy  out  1  high in WAIT_VS or CAPTURE.
- frame_done  out  1  one-cycle pulse at the end of a completed frame.
- frame_cnt  out  8  completed-frame counter, wraps 255 -> 0.
- err_short  out  1  sticky: a frame ended with fewer window lines than expected.
- err_ovf  out  1  sticky: a write was suppressed at the address limit.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0; FSM in IDLE; sync flops cleared.
- Input sampling:
  - pclk, href, vsync and d each pass through a 2-FF synchroniser.
  - pclk_rise = synced pclk 0->1; all data actions occur only in pclk_rise cycles.
  - href and vsync edges are detected on the synced signals.
- FSM:
  - IDLE: go to WAIT_VS when cfg_en=1.
  - WAIT_VS: wait for vsync 1->0 (frame start), then go to CAPTURE. At that edge, latch all cfg_* fields, clear x/y counters, and reset wr_addr to 0.
  - CAPTURE: on vsync 0->1, pulse frame_done, increment frame_cnt and evaluate err_short. Next state is DONE if the single-shot flag latched at frame start is set, else WAIT_VS.
  - DONE: hold; go to IDLE when cfg_en=0.
  - From any state, cfg_en=0 forces IDLE next cycle: no frame_done, no frame_cnt change, an in-flight wr_en still completes.
- Pixel assembly:
  - Byte phase resets to 0 on href 0->1.
  - On pclk_rise with href=1, shift in cam_d; when phase reaches PIX_BYTES-1 a pixel is complete and x increments after use.
  - A partial pixel at href 1->0 is discarded.
- Line counting: on href 1->0, y increments if the line produced at least one pixel.
- Write condition:
  - x0 <= x < x0+w and y0 <= y < y0+h (widths extended by one bit, no wrap).
  - If decim=1, additionally (x-x0)[0]=0 and (y-y0)[0]=0.
- Write timing:
  - wr_en is registered, high exactly 1 cycle.
  - Occurs in the cycle after the pclk_rise that completes the pixel, i.e. 4 clk after the pclk pin edge.
  - wr_addr holds the current value during the strobe and increments afterwards.
- Address limit: when wr_addr = 2^ADDR_W-1 has been written, further writes that frame are suppressed and err_ovf is set. There is no wrap.
- Short-frame check: at frame end, expected lines = h (decim=0) or ceil(h/2) (decim=1). If written lines < expected, set err_short.
- err_short and err_ovf clear only on reset or on a cfg_en 0->1 transition.
- Simultaneous events:
  - vsync rise and a pixel completion in the same cycle: the pixel is written first, then the frame ends.
  - href fall in the same cycle as a pixel completion: the pixel counts on the current line.

Decomposition:
- Package cam_pkg:
  - FSM state enum: IDLE, WAIT_VS, CAPTURE, DONE.
  - SYNC_STAGES=2 constant.
  - Function ceil_half.
- One sub-module, cam_in_sync: 2-FF synchroniser plus edge detect for pclk/href/vsync, and synchronisation of d. Instanced once.

Test Plan:
- Reset and idle check: with rst_n low, all outputs read 0; with cfg_en=0, toggling vsync and href produces no wr_en and busy stays 0.
- Full frame: PIX_BYTES=2, 4x3 frame, window 0,0,4,3, bytes 0x01..0x18 -> 12 writes, addr 0..11, data 0x0102..0x1718, then frame_done once and frame_cnt=1.
- Crop: 8x6 frame, window x0=2 y0=1 w=3 h=2 -> 6 writes, addr 0..5, pixels (2..4,1..2) in raster order.
- Decimation: 8x6 frame, window 0,0,8,6, decim=1 -> 12 writes, pixels at even x and even y.
- Single-shot and abort:
  - Single-shot: cfg_single=1 captures 1 frame and then stays in DONE through a 2nd vsync (no writes); cfg_en low then high re-arms.
  - Abort: cfg_en low mid-line -> IDLE, no frame_done.
- Errors:
  - Short frame: h=6 with only 4 lines sent -> err_short=1.
  - Overflow: ADDR_W=3 with a 16-pixel window -> 8 writes, err_ovf=1, no address wrap.
